ceff_buf: RTL and testbench
===========================

# ceff_buf

Parametrised elastic capture buffer: the multi-entry, flow-controlled successor to the single-register capture stage. It accepts words on a valid/ready input, stores up to DEPTH of them in order, and presents them on a valid/ready output. It optionally retains the last delivered word on the output when empty. It sits between producer and consumer stages wherever a single capture register cannot absorb backpressure.

## Interface
- SIZE, 1: data width in bits (≥1).
- DEPTH, 2: number of storage entries (≥1; need not be a power of two).
- HOLD, 0: 1 = data_o keeps the last popped word while empty; 0 = data_o is zero while empty.
- clk  input  1  single clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0); clears all state immediately.
- flush_i  input  1  synchronous clear of contents.
- valid_i  input  1  producer has a word.
- ready_o  output  1  buffer can accept a word.
- data_i  input  SIZE  input word.
- valid_o  output  1  head word available.
- ready_i  input  1  consumer accepts head word.
- data_o  output  SIZE  head word, or the empty-state value per HOLD.
- count_o  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full_o  output  1  count_o == DEPTH.
- empty_o  output  1  count_o == 0.

## Operation
- Storage is a circular array of DEPTH×SIZE with registered wr_ptr, rd_ptr and count.
- push = valid_i & ready_o. pop = valid_o & ready_i.
- ready_o = !full_o. It is derived from registered count only and does not depend on ready_i in the same cycle, so there is no combinational in→out path.
- valid_o = !empty_o.
- data_o = mem[rd_ptr] when non-empty.
- When empty, data_o = last_q if HOLD=1, else 0.
- On push: write mem[wr_ptr], advance wr_ptr.
- On pop: advance rd_ptr; if HOLD=1, last_q <= mem[rd_ptr].
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0. Explicit compare; no reliance on power-of-two overflow.
- Count update per cycle:
  - push only: count+1.
  - pop only: count−1.
  - both, or neither: count unchanged.
- Simultaneous push and pop when non-empty and non-full: both take effect; count unchanged.
- Full: ready_o=0, so no push that cycle even if a pop occurs. ready_o rises the cycle after the pop.
- Empty: no pop. A push makes valid_o=1 the following cycle; there is no same-cycle bypass.
- flush_i=1: pointers, count and last_q go to 0 at the clock edge. This overrides any push or pop in the same cycle; a word offered that cycle is discarded.
- A protocol violation by the producer (valid_i=1 while ready_o=0) is ignored: no write, no state change.
- Memory contents are not reset. Only control state and last_q are reset.

## Timing
- Reset values: ready_o=1 (0 while reset is asserted is not required), valid_o=0, data_o=0, count_o=0, full_o=0, empty_o=1.
- Reset assertion takes effect without a clock edge. Reset mid-operation discards all contents; post-reset behaviour is identical to power-up.
- Latency: a word pushed on edge N is visible on data_o/valid_o after edge N, i.e. in cycle N+1 if the buffer was empty. Otherwise it appears after all older words have been popped.
- Throughput: one word per cycle in steady state when 0 < count < DEPTH.
- DEPTH=1 alternates at best: accept, then deliver, then accept, for half rate. This is required behaviour, not a defect.
- All outputs are functions of registered state only. The only exception is data_o, which is a mux on rd_ptr.

## Test plan
- Reset/idle: assert reset=0 mid-stream with count=2, then release → count_o=0, empty_o=1, valid_o=0, data_o=0, ready_o=1 without waiting for a clock edge.
- Fill/drain: SIZE=8, DEPTH=3, ready_i=0. Push 0x11, 0x22, 0x33, then offer 0x44 → full_o=1, ready_o=0, 0x44 not stored. Raise ready_i → outputs 0x11, 0x22, 0x33 in order on consecutive cycles, then empty_o=1.
- Wrap-around: DEPTH=3, continuous push with ready_i=1 for 10 words 0x00..0x09 → same sequence out, each word one cycle later, count_o stays at 1.
- Simultaneous at full: DEPTH=2 full with 0xA0, 0xA1. Pop while valid_i=1 with 0xA2 → 0xA2 rejected that cycle, accepted next cycle; output order 0xA0, 0xA1, 0xA2.
- HOLD mode: HOLD=1. Push 0x5C, pop it → empty_o=1, data_o stays 0x5C. Repeat with HOLD=0 → data_o=0.
- Flush priority: count=2, flush_i=1 together with push of 0x77 and a pop → next cycle count_o=0, valid_o=0, data_o=0, and 0x77 never appears.

Source files
------------

// File: rtl/ceff_buf.sv
// ceff_buf: elastic capture buffer, DEPTH-entry circular store
// with valid/ready on both sides and optional hold-last output.
module ceff_buf #(
  parameter int SIZE  = 1,
  parameter int DEPTH = 2,
  parameter int HOLD  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [SIZE-1:0]              data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [SIZE-1:0]              data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SIZE-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;
  logic [SIZE-1:0] r_last;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [PW-1:0]   w_wr_nx;
  logic [PW-1:0]   w_rd_nx;
  logic [SIZE-1:0] w_head;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = valid_i & ~w_full;
  assign w_pop   = ready_i & ~w_empty;
  assign w_head  = r_mem[r_rd];

  // Explicit wrap so non-power-of-two depths work.
  assign w_wr_nx = (r_wr == PW'(DEPTH-1)) ? '0 : r_wr + PW'(1);
  assign w_rd_nx = (r_rd == PW'(DEPTH-1)) ? '0 : r_rd + PW'(1);

  always_ff @(posedge clk) begin
    if (w_push && !flush_i) begin
      r_mem[r_wr] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_last <= '0;
    end else if (flush_i) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_last <= '0;
    end else begin
      if (w_push) begin
        r_wr <= w_wr_nx;
      end
      if (w_pop) begin
        r_rd <= w_rd_nx;
        if (HOLD != 0) begin
          r_last <= w_head;
        end
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign ready_o = ~w_full;
  assign valid_o = ~w_empty;
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign count_o = r_cnt;

  always_comb begin
    data_o = '0;
    if (!w_empty) begin
      data_o = w_head;
    end else if (HOLD != 0) begin
      data_o = r_last;
    end
  end

endmodule

// File: tb/tb_ceff_buf.sv
// tb_ceff_buf: queue-model scoreboard plus directed vectors
// on a DEPTH=3/HOLD=0 buffer and a DEPTH=2/HOLD=1 buffer.
module tb_ceff_buf;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_flush, a_valid, a_ready, a_rdy_o, a_val_o;
  logic       a_full, a_empty;
  logic [7:0] a_din, a_dout;
  logic [1:0] a_cnt;

  logic       b_flush, b_valid, b_ready, b_rdy_o, b_val_o;
  logic       b_full, b_empty;
  logic [7:0] b_din, b_dout;
  logic [1:0] b_cnt;

  ceff_buf #(.SIZE(8), .DEPTH(3), .HOLD(0)) u_a (
    .clk(clk), .reset(rst), .flush_i(a_flush),
    .valid_i(a_valid), .ready_o(a_rdy_o), .data_i(a_din),
    .valid_o(a_val_o), .ready_i(a_ready), .data_o(a_dout),
    .count_o(a_cnt), .full_o(a_full), .empty_o(a_empty)
  );

  ceff_buf #(.SIZE(8), .DEPTH(2), .HOLD(1)) u_b (
    .clk(clk), .reset(rst), .flush_i(b_flush),
    .valid_i(b_valid), .ready_o(b_rdy_o), .data_i(b_din),
    .valid_o(b_val_o), .ready_i(b_ready), .data_o(b_dout),
    .count_o(b_cnt), .full_o(b_full), .empty_o(b_empty)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: an ordered queue of accepted words.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] lb;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      qa.delete();
    end else if (a_flush) begin
      qa.delete();
    end else begin
      automatic bit pu = a_valid && (qa.size() < 3);
      automatic bit po = a_ready && (qa.size() > 0);
      if (po) void'(qa.pop_front());
      if (pu) qa.push_back(a_din);
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      qb.delete();
      lb = 8'h00;
    end else if (b_flush) begin
      qb.delete();
      lb = 8'h00;
    end else begin
      automatic bit pu = b_valid && (qb.size() < 2);
      automatic bit po = b_ready && (qb.size() > 0);
      if (po) lb = qb.pop_front();
      if (pu) qb.push_back(b_din);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      automatic int na = qa.size();
      automatic int nb = qb.size();
      chk("a_count", int'(a_cnt), na);
      chk("a_valid", int'(a_val_o), int'(na > 0));
      chk("a_ready", int'(a_rdy_o), int'(na < 3));
      chk("a_full", int'(a_full), int'(na == 3));
      chk("a_empty", int'(a_empty), int'(na == 0));
      chk("a_data", int'(a_dout), (na > 0) ? int'(qa[0]) : 0);
      chk("b_count", int'(b_cnt), nb);
      chk("b_valid", int'(b_val_o), int'(nb > 0));
      chk("b_ready", int'(b_rdy_o), int'(nb < 2));
      chk("b_full", int'(b_full), int'(nb == 2));
      chk("b_empty", int'(b_empty), int'(nb == 0));
      chk("b_data", int'(b_dout), (nb > 0) ? int'(qb[0]) : int'(lb));
    end
  end

  task automatic idle_a();
    a_flush = 0; a_valid = 0; a_ready = 0; a_din = 8'h00;
  endtask

  task automatic idle_b();
    b_flush = 0; b_valid = 0; b_ready = 0; b_din = 8'h00;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    idle_a();
    idle_b();
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    chk("rst_a_ready", int'(a_rdy_o), 1);
    chk("rst_a_empty", int'(a_empty), 1);
    chk("rst_b_data", int'(b_dout), 0);

    // Async reset mid-stream with two words held
    a_valid = 1; a_din = 8'h01; cyc();
    a_din = 8'h02; cyc();
    idle_a();
    chk("pre_rst_cnt", int'(a_cnt), 2);
    #2 rst = 1'b0;
    #1;
    chk("arst_cnt", int'(a_cnt), 0);
    chk("arst_empty", int'(a_empty), 1);
    chk("arst_valid", int'(a_val_o), 0);
    chk("arst_data", int'(a_dout), 0);
    chk("arst_ready", int'(a_rdy_o), 1);
    cyc();
    rst = 1'b1;
    cyc();

    // Fill then drain
    a_valid = 1; a_din = 8'h11; cyc();
    a_din = 8'h22; cyc();
    a_din = 8'h33; cyc();
    a_din = 8'h44; cyc();
    chk("fill_full", int'(a_full), 1);
    chk("fill_ready", int'(a_rdy_o), 0);
    chk("fill_cnt", int'(a_cnt), 3);
    a_valid = 0; a_ready = 1;
    chk("drain0", int'(a_dout), 8'h11);
    cyc();
    chk("drain1", int'(a_dout), 8'h22);
    cyc();
    chk("drain2", int'(a_dout), 8'h33);
    cyc();
    chk("drain_empty", int'(a_empty), 1);
    chk("drain_data0", int'(a_dout), 0);

    // Wrap-around streaming
    for (int i = 0; i < 10; i++) begin
      a_valid = 1; a_ready = 1; a_din = 8'(i);
      cyc();
      chk("wrap_data", int'(a_dout), i);
      chk("wrap_cnt", int'(a_cnt), 1);
    end
    a_valid = 0;
    cyc();
    idle_a();

    // Flush beats push and pop
    a_valid = 1; a_din = 8'h61; cyc();
    a_din = 8'h62; cyc();
    chk("pre_flush_cnt", int'(a_cnt), 2);
    a_flush = 1; a_valid = 1; a_din = 8'h77; a_ready = 1;
    cyc();
    chk("flush_cnt", int'(a_cnt), 0);
    chk("flush_valid", int'(a_val_o), 0);
    chk("flush_data", int'(a_dout), 0);
    idle_a(); a_ready = 1;
    repeat (2) cyc();
    chk("flush_stays_empty", int'(a_empty), 1);
    idle_a();

    // Simultaneous pop/offer at full, DEPTH=2
    b_valid = 1; b_din = 8'hA0; cyc();
    b_din = 8'hA1; cyc();
    chk("b_full2", int'(b_full), 1);
    b_din = 8'hA2; b_ready = 1;
    chk("b_head_a0", int'(b_dout), 8'hA0);
    chk("b_rdy_low", int'(b_rdy_o), 0);
    cyc();
    chk("b_head_a1", int'(b_dout), 8'hA1);
    chk("b_cnt1", int'(b_cnt), 1);
    cyc();
    chk("b_head_a2", int'(b_dout), 8'hA2);
    chk("b_cnt_a2", int'(b_cnt), 1);
    b_valid = 0;
    cyc();
    chk("b_hold_a2", int'(b_dout), 8'hA2);
    chk("b_empty2", int'(b_empty), 1);
    idle_b();

    // HOLD=1 versus HOLD=0 after single push/pop
    a_valid = 1; a_din = 8'h5C; b_valid = 1; b_din = 8'h5C;
    cyc();
    a_valid = 0; b_valid = 0; a_ready = 1; b_ready = 1;
    cyc();
    chk("hold1_data", int'(b_dout), 8'h5C);
    chk("hold1_empty", int'(b_empty), 1);
    chk("hold0_data", int'(a_dout), 0);
    chk("hold0_empty", int'(a_empty), 1);
    repeat (2) cyc();
    chk("hold1_keep", int'(b_dout), 8'h5C);

    // Flush clears the held word
    b_flush = 1; cyc();
    chk("hold_flush", int'(b_dout), 0);
    idle_a();
    idle_b();
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
